// File: rtl/jogo_pkg.sv
// jogo_pkg: shared FSM state encoding, difficulty codes and default sizing for the game blocks
package jogo_pkg;
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    JOGANDO = 3'd2,
    TROCA   = 3'd3,
    PAUSA   = 3'd4
  } estado_t;
  localparam logic [1:0] NIVEL_0 = 2'd0;
  localparam logic [1:0] NIVEL_1 = 2'd1;
  localparam logic [1:0] NIVEL_2 = 2'd2;
  localparam logic [1:0] NIVEL_3 = 2'd3;
  localparam int NUM_POS_DEF      = 9;
  localparam int PAUSA_CICLOS_DEF = 50_000_000;
endpackage

// File: rtl/gerador_lfsr.sv
// gerador_lfsr: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
//  clock in  system clock
//  reset in  asynchronous active-high reset, loads SEED
//  Q     out current LFSR state
module gerador_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] Q
);
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign Q = lfsr_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
endmodule

// File: rtl/sequenciador_alvo.sv
// sequenciador_alvo: round sequencer choosing the target LED and gating the round timer
//  clock, reset          clock and asynchronous active-high reset
//  iniciar, parar        start (sampled when idle) / abort (highest priority)
//  nivel_dificuldade     level 0 sequential targets, 1-3 pseudo-random
//  ganhou/perdeu_ponto   round result, honoured only while playing
//  position_led          current target, always < NUM_POS
//  conta_nivel           round timer enable
//  reset_nivel/ponto     one-cycle clears of round timer / score
//  rodada_ativa          high while playing
//  rodadas               completed rounds, saturating at 255
module sequenciador_alvo
  import jogo_pkg::*;
#(
  parameter int          NUM_POS      = NUM_POS_DEF,
  parameter int          PAUSA_CICLOS = PAUSA_CICLOS_DEF,
  parameter int          PAUSA_N      = 26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [1:0] nivel_dificuldade,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  output logic [3:0] position_led,
  output logic       conta_nivel,
  output logic       reset_nivel,
  output logic       reset_ponto,
  output logic       rodada_ativa,
  output logic [7:0] rodadas
);
  localparam logic [4:0]         NP        = 5'(NUM_POS);
  localparam logic [PAUSA_N-1:0] PAUSA_FIM = PAUSA_N'(PAUSA_CICLOS - 1);
  estado_t              estado_q, estado_d;
  logic [3:0]           pos_q, pos_d, alvo;
  logic [7:0]           rodadas_q, rodadas_d;
  logic [PAUSA_N-1:0]   pausa_q, pausa_d;
  logic                 conta_q, conta_d, rst_nivel_q, rst_nivel_d;
  logic                 rst_ponto_q, rst_ponto_d, ativa_q, ativa_d;
  logic [15:0]          lfsr;
  logic [4:0]           pos5, prox_seq, c_raw, c_mod, c_sel;
  logic                 unused_lfsr;
  gerador_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clock(clock), .reset(reset), .Q(lfsr));
  assign unused_lfsr = ^lfsr[15:4];
  // Random pick folds 0..15 into range, then steps past the current target so it never repeats.
  assign pos5     = {1'b0, pos_q};
  assign prox_seq = (pos5 == NP - 5'd1) ? 5'd0 : pos5 + 5'd1;
  assign c_raw    = {1'b0, lfsr[3:0]};
  assign c_mod    = (c_raw >= NP) ? c_raw - NP : c_raw;
  assign c_sel    = (c_mod != pos5) ? c_mod : (c_mod == NP - 5'd1) ? 5'd0 : c_mod + 5'd1;
  assign alvo     = (nivel_dificuldade == NIVEL_0) ? 4'(prox_seq) : 4'(c_sel);
  always_comb begin
    estado_d  = estado_q;
    pos_d     = pos_q;
    rodadas_d = rodadas_q;
    pausa_d   = (estado_q == PAUSA) ? pausa_q + 1'b1 : '0;
    case (estado_q)
      OCIOSO:  estado_d = iniciar ? PREPARA : OCIOSO;
      PREPARA: begin
        estado_d  = JOGANDO;
        rodadas_d = '0;
        pos_d     = '0;
      end
      JOGANDO: if (ganhou_ponto | perdeu_ponto) begin
        estado_d  = TROCA;
        rodadas_d = (rodadas_q == 8'hFF) ? rodadas_q : rodadas_q + 8'd1;
      end
      TROCA: begin
        estado_d = PAUSA;
        pos_d    = alvo;
      end
      PAUSA:   estado_d = (pausa_q == PAUSA_FIM) ? JOGANDO : PAUSA;
      default: estado_d = OCIOSO;
    endcase
    if (parar) begin
      estado_d  = OCIOSO;
      pos_d     = pos_q;
      rodadas_d = rodadas_q;
    end
    // Outputs are decoded from the next state so they are registered alongside it.
    conta_d     = estado_d == JOGANDO;
    ativa_d     = estado_d == JOGANDO;
    rst_nivel_d = estado_d == PREPARA || estado_d == TROCA;
    rst_ponto_d = estado_d == PREPARA;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado_q    <= OCIOSO;
      pos_q       <= '0;
      rodadas_q   <= '0;
      pausa_q     <= '0;
      conta_q     <= 1'b0;
      rst_nivel_q <= 1'b0;
      rst_ponto_q <= 1'b0;
      ativa_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      pos_q       <= pos_d;
      rodadas_q   <= rodadas_d;
      pausa_q     <= pausa_d;
      conta_q     <= conta_d;
      rst_nivel_q <= rst_nivel_d;
      rst_ponto_q <= rst_ponto_d;
      ativa_q     <= ativa_d;
    end
  assign position_led = pos_q;
  assign rodadas      = rodadas_q;
  assign conta_nivel  = conta_q;
  assign reset_nivel  = rst_nivel_q;
  assign reset_ponto  = rst_ponto_q;
  assign rodada_ativa = ativa_q;
endmodule

// File: tb/tb_sequenciador_alvo.sv
// tb_sequenciador_alvo: directed and table-driven bench for sequenciador_alvo
module tb_sequenciador_alvo;
  import jogo_pkg::*;
  logic       clock = 1'b0, reset = 1'b1, iniciar = 1'b0, parar = 1'b0;
  logic       ganhou_ponto = 1'b0, perdeu_ponto = 1'b0;
  logic [1:0] nivel_dificuldade = 2'd0;
  logic [3:0] position_led;
  logic       conta_nivel, reset_nivel, reset_ponto, rodada_ativa;
  logic [7:0] rodadas;
  int checks = 0, errors = 0;
  typedef struct {logic g; logic p; int pos; int rod;} vec_t;
  vec_t tab[10];
  sequenciador_alvo #(.NUM_POS(9), .PAUSA_CICLOS(4), .PAUSA_N(3), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
    .nivel_dificuldade(nivel_dificuldade), .ganhou_ponto(ganhou_ponto), .perdeu_ponto(perdeu_ponto),
    .position_led(position_led), .conta_nivel(conta_nivel), .reset_nivel(reset_nivel),
    .reset_ponto(reset_ponto), .rodada_ativa(rodada_ativa), .rodadas(rodadas)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  // Fires one event in JOGANDO, then walks TROCA+PAUSA (bounded) until the timer is enabled again.
  task automatic evento(input logic g, input logic p, input logic inj,
                        output int low, output int rn, output int pn);
    ganhou_ponto = g;
    perdeu_ponto = p;
    tick;
    ganhou_ponto = 1'b0;
    perdeu_ponto = 1'b0;
    low = 0;
    rn = 0;
    pn = -1;
    for (int i = 0; i < 20 && !conta_nivel; i++) begin
      low++;
      if (reset_nivel) rn++;
      if (i == 1) pn = int'(position_led);
      if (inj) begin
        ganhou_ponto = 1'b1;
        perdeu_ponto = i[0];
      end
      tick;
    end
    ganhou_ponto = 1'b0;
    perdeu_ponto = 1'b0;
  endtask
  initial begin
    int low, rn, pn, prev, r0, p0;
    logic g, p, inj;
    tab[0] = '{1'b1, 1'b0, 1, 1};
    tab[1] = '{1'b1, 1'b0, 2, 2};
    tab[2] = '{1'b0, 1'b1, 3, 3};
    tab[3] = '{1'b1, 1'b0, 4, 4};
    tab[4] = '{1'b1, 1'b1, 5, 5};
    tab[5] = '{1'b1, 1'b0, 6, 6};
    tab[6] = '{1'b1, 1'b0, 7, 7};
    tab[7] = '{1'b0, 1'b1, 8, 8};
    tab[8] = '{1'b1, 1'b0, 0, 9};
    tab[9] = '{1'b1, 1'b0, 1, 10};
    repeat (2) tick;
    chk("rst_pos", int'(position_led), 0);
    chk("rst_conta", int'(conta_nivel), 0);
    chk("rst_rnivel", int'(reset_nivel), 0);
    chk("rst_rponto", int'(reset_ponto), 0);
    chk("rst_ativa", int'(rodada_ativa), 0);
    chk("rst_rodadas", int'(rodadas), 0);
    chk("rst_lfsr", int'(dut.lfsr), 'hACE1);
    reset = 1'b0;
    tick;
    chk("idle_state", int'(dut.estado_q), int'(OCIOSO));
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    chk("prep_rponto", int'(reset_ponto), 1);
    chk("prep_rnivel", int'(reset_nivel), 1);
    chk("prep_conta", int'(conta_nivel), 0);
    tick;
    chk("jog_rponto", int'(reset_ponto), 0);
    chk("jog_rnivel", int'(reset_nivel), 0);
    chk("jog_conta", int'(conta_nivel), 1);
    chk("jog_ativa", int'(rodada_ativa), 1);
    chk("jog_pos", int'(position_led), 0);
    for (int i = 0; i < 10; i++) begin
      evento(tab[i].g, tab[i].p, 1'b0, low, rn, pn);
      chk("seq_low", low, 5);
      chk("seq_rnivel", rn, 1);
      chk("seq_pos_n2", pn, tab[i].pos);
      chk("seq_pos", int'(position_led), tab[i].pos);
      chk("seq_rodadas", int'(rodadas), tab[i].rod);
    end
    nivel_dificuldade = 2'd2;
    prev = int'(position_led);
    for (int i = 0; i < 250; i++) begin
      g = 1'($urandom_range(0, 1));
      p = g ? 1'($urandom_range(0, 1)) : 1'b1;
      inj = 1'($urandom_range(0, 1));
      r0 = int'(rodadas);
      evento(g, p, inj, low, rn, pn);
      chk("rnd_low", low, 5);
      chk("rnd_range", int'(pn >= 0 && pn < 9), 1);
      chk("rnd_norepeat", int'(pn != prev), 1);
      chk("rnd_rodadas", int'(rodadas), (r0 == 255) ? 255 : r0 + 1);
      prev = pn;
    end
    chk("sat_rodadas", int'(rodadas), 255);
    p0 = int'(position_led);
    parar = 1'b1;
    ganhou_ponto = 1'b1;
    iniciar = 1'b1;
    tick;
    ganhou_ponto = 1'b0;
    chk("stopj_state", int'(dut.estado_q), int'(OCIOSO));
    chk("stopj_conta", int'(conta_nivel), 0);
    chk("stopj_ativa", int'(rodada_ativa), 0);
    chk("stopj_pos", int'(position_led), p0);
    chk("stopj_rodadas", int'(rodadas), 255);
    tick;
    chk("stop_hold", int'(dut.estado_q), int'(OCIOSO));
    parar = 1'b0;
    tick;
    iniciar = 1'b0;
    chk("restart_rponto", int'(reset_ponto), 1);
    tick;
    chk("restart_conta", int'(conta_nivel), 1);
    chk("restart_rodadas", int'(rodadas), 0);
    chk("restart_pos", int'(position_led), 0);
    ganhou_ponto = 1'b1;
    tick;
    ganhou_ponto = 1'b0;
    tick;
    tick;
    chk("stopp_in_pausa", int'(dut.estado_q), int'(PAUSA));
    p0 = int'(position_led);
    parar = 1'b1;
    tick;
    parar = 1'b0;
    chk("stopp_state", int'(dut.estado_q), int'(OCIOSO));
    chk("stopp_conta", int'(conta_nivel), 0);
    chk("stopp_rnivel", int'(reset_nivel), 0);
    chk("stopp_pos", int'(position_led), p0);
    chk("stopp_rodadas", int'(rodadas), 1);
    iniciar = 1'b1;
    tick;
    iniciar = 1'b0;
    tick;
    ganhou_ponto = 1'b1;
    tick;
    ganhou_ponto = 1'b0;
    tick;
    tick;
    chk("rstp_in_pausa", int'(dut.estado_q), int'(PAUSA));
    #2 reset = 1'b1;
    tick;
    chk("rstp_state", int'(dut.estado_q), int'(OCIOSO));
    chk("rstp_pos", int'(position_led), 0);
    chk("rstp_conta", int'(conta_nivel), 0);
    chk("rstp_rnivel", int'(reset_nivel), 0);
    chk("rstp_rponto", int'(reset_ponto), 0);
    chk("rstp_ativa", int'(rodada_ativa), 0);
    chk("rstp_rodadas", int'(rodadas), 0);
    chk("rstp_lfsr", int'(dut.lfsr), 'hACE1);
    reset = 1'b0;
    tick;
    chk("lfsr_step", int'(dut.lfsr), 'h59C3);
    chk("post_rst_state", int'(dut.estado_q), int'(OCIOSO));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
